// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: state encoding,
// opcode values and default widths.
package alu_op_sequencer_pkg;

  // Sequencer states; encoding is fixed so it can be probed on a board.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    DONE   = 2'd3
  } seq_state_e;

  // Opcode as carried on in_sub / ALU Cin.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;

  // True in the two states that accept an input word.
  function automatic logic is_load_state(input seq_state_e st);
    return (st == LOAD_A) || (st == LOAD_B);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational add/sub ALU. Cin=0 gives A+B, Cin=1 gives A-B computed as
// A + ~B + 1, so Carry is the "no borrow" flag on subtraction.
module alu_op_sequencer_alu #(
  parameter int WIDTH = 8
) (
  input  logic             Cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Carry,
  output logic             Zero,
  output logic             Overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // Conditional inversion of B turns the adder into a subtractor.
  assign b_eff = B ^ {WIDTH{Cin}};
  assign sum   = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};

  assign Result   = sum[WIDTH-1:0];
  assign Carry    = sum[WIDTH];
  assign Zero     = (sum[WIDTH-1:0] == '0);
  // Signed overflow: operands of equal sign producing a result of other sign.
  assign Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/alu_op_sequencer.sv
// Handshaked, registered front-end for the combinational add/sub ALU.
// Collects operand A, then operand B with the opcode, runs one EXEC cycle,
// and holds the captured result and flags until the consumer accepts them.
// Optional feature macro: ACC_CHAIN_EN adds acc_mode, which on accept feeds
// the result back as operand A and resumes at LOAD_B.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_sub,
  input  logic             flush,
  output logic             alu_cin,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
`ifdef ACC_CHAIN_EN
  input  logic             acc_mode,
`endif
  output logic [CNT_W-1:0] op_count
);

  seq_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             overflow_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] op_count_q;
  logic [CNT_W-1:0] op_count_d;
  logic             in_fire;
  logic             out_fire;
  seq_state_e       after_done_d;

  // Handshake qualifiers; in_ready is purely a function of the state register.
  assign in_ready = is_load_state(state_q);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Accepted-result counter wraps naturally at 2^CNT_W.
  assign op_count_d = op_count_q + CNT_W'(1);

  // Where DONE goes after the consumer accepts: chaining resumes at LOAD_B.
`ifdef ACC_CHAIN_EN
  assign after_done_d = acc_mode ? LOAD_B : LOAD_A;
`else
  assign after_done_d = LOAD_A;
`endif

  // Sequencer FSM with all datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else if (flush) begin
      // Abort wins over any handshake; operands and counter are kept.
      state_q     <= LOAD_A;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD_A: begin
          if (in_fire) begin
            a_q     <= data_in;
            state_q <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (in_fire) begin
            b_q     <= data_in;
            op_q    <= in_sub;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          // ALU inputs have been stable from registers for this whole cycle.
          result_q    <= alu_result;
          carry_q     <= alu_carry;
          zero_q      <= alu_zero;
          overflow_q  <= alu_overflow;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            op_count_q  <= op_count_d;
            state_q     <= after_done_d;
`ifdef ACC_CHAIN_EN
            if (acc_mode) begin
              a_q <= result_q;
            end
`endif
          end
        end
        default: begin
          state_q <= LOAD_A;
        end
      endcase
    end
  end

  // ALU is driven continuously from the operand registers.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_cin = op_q;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign overflow  = overflow_q;
  assign op_count  = op_count_q;

endmodule
